// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Brief    : Shared sizes, band types and FSM states for the FFT band packer.
//  Revision : 1.0 - initial release
// ============================================================================
package fft_pkg;

  localparam int N_BINS        = 32;
  localparam int N_BANDS       = 8;
  localparam int DW            = 16;
  localparam int BW            = 32;
  localparam int BINS_PER_BAND = N_BINS / N_BANDS;
  localparam int IDX_W         = $clog2(N_BINS);
  localparam int BAND_W        = $clog2(N_BANDS);
  localparam int MAG_W         = DW + 2;

  typedef logic [BW-1:0]             band_t;
  typedef band_t [N_BANDS-1:0]       band_arr_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCUM   = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cplx_abs_sum.sv
`default_nettype none
// ============================================================================
//  Module   : cplx_abs_sum
//  Brief    : Combinational |re| + |im| magnitude approximation.
//  Revision : 1.0 - initial release
// ============================================================================
module cplx_abs_sum
  import fft_pkg::*;
(
  input  logic signed [DW-1:0] i_re,
  input  logic signed [DW-1:0] i_im,
  output logic [MAG_W-1:0]     o_mag
);

  // Sign-extend by one bit first so that |-32768| = 32768 is representable.
  logic signed [DW:0] w_re_ext;
  logic signed [DW:0] w_im_ext;
  logic [DW:0]        w_re_abs;
  logic [DW:0]        w_im_abs;

  assign w_re_ext = {i_re[DW-1], i_re};
  assign w_im_ext = {i_im[DW-1], i_im};

  // Absolute value of each component in DW+1 bits.
  always_comb begin
    w_re_abs = w_re_ext[DW] ? DW'(0) - w_re_ext : w_re_ext;
    w_im_abs = w_im_ext[DW] ? DW'(0) - w_im_ext : w_im_ext;
  end

  assign o_mag = {1'b0, w_re_abs} + {1'b0, w_im_abs};

endmodule
`default_nettype wire

// File: rtl/fft_band_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_band_packer
//  Brief    : Reduces one frame of FFT bins to 8 band magnitudes and publishes
//             them as a packed word with a done/ack handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module fft_band_packer
  import fft_pkg::*;
(
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_bin_valid,
  input  logic [IDX_W-1:0]        i_bin_idx,
  input  logic signed [DW-1:0]    i_bin_re,
  input  logic signed [DW-1:0]    i_bin_im,
  input  logic                    i_ack,
  output logic [N_BANDS*BW-1:0]   o_freqs,
  output logic                    o_fft_done,
  output logic                    o_seq_err,
  output logic [7:0]              o_drop_cnt
);

  state_t             r_state;
  logic [IDX_W-1:0]   r_exp;
  band_arr_t          r_acc;
  band_arr_t          r_freqs;
  logic               r_done;
  logic               r_seq_err;
  logic [7:0]         r_drop_cnt;

  logic [MAG_W-1:0]   w_mag;
  band_t              w_mag_ext;
  logic [BAND_W-1:0]  w_band;
  logic               w_start;

  cplx_abs_sum u_abs (
    .i_re  (i_bin_re),
    .i_im  (i_bin_im),
    .o_mag (w_mag)
  );

  assign w_mag_ext = BW'(w_mag);
  // Bands are contiguous groups of bins, so the band is the index's top bits.
  assign w_band    = i_bin_idx[IDX_W-1 -: BAND_W];
  // A bin with index 0 opens a new frame from any state.
  assign w_start   = i_bin_valid && (i_bin_idx == '0);

  // Frame sequencing, accumulation, publish and handshake in one FSM.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_exp      <= '0;
      r_acc      <= '0;
      r_freqs    <= '0;
      r_done     <= 1'b0;
      r_seq_err  <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_seq_err <= 1'b0;
      // Ack clears done; a publish in the same cycle overrides this below.
      if (i_ack) begin
        r_done <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_acc    <= '0;
            r_acc[0] <= w_mag_ext;
            r_exp    <= IDX_W'(1);
            r_state  <= S_ACCUM;
          end
        end

        S_ACCUM: begin
          if (i_bin_valid) begin
            if (i_bin_idx == r_exp) begin
              r_acc[w_band] <= r_acc[w_band] + w_mag_ext;
              r_exp         <= r_exp + 1'b1;
              if (i_bin_idx == IDX_W'(N_BINS - 1)) begin
                r_state <= S_PUBLISH;
              end
            end else if (i_bin_idx == '0) begin
              // Aborted frame, but this bin starts the next one.
              r_seq_err <= 1'b1;
              r_acc     <= '0;
              r_acc[0]  <= w_mag_ext;
              r_exp     <= IDX_W'(1);
            end else begin
              r_seq_err <= 1'b1;
              r_state   <= S_IDLE;
            end
          end
        end

        S_PUBLISH: begin
          if (!r_done || i_ack) begin
            r_freqs <= r_acc;
            r_done  <= 1'b1;
          end else if (r_drop_cnt != 8'hFF) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
          end
          // A new frame may begin in the publish cycle; r_acc is read above
          // before these non-blocking updates land.
          if (w_start) begin
            r_acc    <= '0;
            r_acc[0] <= w_mag_ext;
            r_exp    <= IDX_W'(1);
            r_state  <= S_ACCUM;
          end else begin
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_freqs    = r_freqs;
  assign o_fft_done = r_done;
  assign o_seq_err  = r_seq_err;
  assign o_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fft_band_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_band_packer
//  Brief    : Directed self-checking bench for fft_band_packer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fft_band_packer;

  logic               clk;
  logic               rst_n;
  logic               bin_valid;
  logic [4:0]         bin_idx;
  logic signed [15:0] bin_re;
  logic signed [15:0] bin_im;
  logic               ack;
  logic [255:0]       freqs;
  logic               fft_done;
  logic               seq_err;
  logic [7:0]         drop_cnt;

  int n_vec;
  int n_err;

  logic [255:0] c_f8;
  logic [255:0] c_f12;
  logic [255:0] c_f20;
  logic [255:0] c_fmax;

  fft_band_packer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_bin_valid (bin_valid),
    .i_bin_idx   (bin_idx),
    .i_bin_re    (bin_re),
    .i_bin_im    (bin_im),
    .i_ack       (ack),
    .o_freqs     (freqs),
    .o_fft_done  (fft_done),
    .o_seq_err   (seq_err),
    .o_drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs (called at a negedge) and return at the next
  // negedge, where outputs reflect the intervening rising edge.
  task automatic cyc(input logic v, input logic [4:0] ix,
                     input logic signed [15:0] r, input logic signed [15:0] m,
                     input logic a);
    bin_valid = v;
    bin_idx   = ix;
    bin_re    = r;
    bin_im    = m;
    ack       = a;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 16'sd0, 16'sd0, 1'b0);
  endtask

  task automatic do_ack();
    cyc(1'b0, 5'd0, 16'sd0, 16'sd0, 1'b1);
  endtask

  task automatic frame(input int lo, input int hi,
                       input logic signed [15:0] r, input logic signed [15:0] m);
    for (int i = lo; i <= hi; i++) cyc(1'b1, 5'(i), r, m, 1'b0);
  endtask

  task automatic test_reset();
    n_vec++; if (freqs !== 256'd0) begin n_err++; $display("FAIL reset_freqs: got %h expected 0", freqs); end
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", fft_done); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
    n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL reset_drop: got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_unit_frame();
    frame(0, 31, 16'sd1, -16'sd1);
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL unit_latency: done got %b expected 0", fft_done); end
    idle();
    n_vec++; if (fft_done !== 1'b1) begin n_err++; $display("FAIL unit_done: got %b expected 1", fft_done); end
    n_vec++; if (freqs !== c_f8) begin n_err++; $display("FAIL unit_freqs: got %h expected %h", freqs, c_f8); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL unit_seq_err: got %b expected 0", seq_err); end
    do_ack();
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL unit_ack: done got %b expected 0", fft_done); end
    idle();
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL unit_ack_hold: done got %b expected 0", fft_done); end
  endtask

  task automatic test_max_bin();
    frame(0, 30, 16'sd0, 16'sd0);
    cyc(1'b1, 5'd31, -16'sd32768, -16'sd32768, 1'b0);
    idle();
    n_vec++; if (freqs !== c_fmax) begin n_err++; $display("FAIL max_freqs: got %h expected %h", freqs, c_fmax); end
    n_vec++; if (fft_done !== 1'b1) begin n_err++; $display("FAIL max_done: got %b expected 1", fft_done); end
    do_ack();
  endtask

  task automatic test_seq_err();
    frame(0, 9, 16'sd1, -16'sd1);
    cyc(1'b1, 5'd11, 16'sd1, -16'sd1, 1'b0);
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL skip_pulse: got %b expected 1", seq_err); end
    idle();
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL skip_pulse_len: got %b expected 0", seq_err); end
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL skip_no_pub: done got %b expected 0", fft_done); end
    n_vec++; if (freqs !== c_fmax) begin n_err++; $display("FAIL skip_freqs_kept: got %h expected %h", freqs, c_fmax); end
    // A clean frame after the abort.
    frame(0, 31, 16'sd1, -16'sd1);
    idle();
    n_vec++; if (freqs !== c_f8 || fft_done !== 1'b1) begin n_err++; $display("FAIL skip_recover: freqs %h done %b expected %h done 1", freqs, fft_done, c_f8); end
    do_ack();
    // Restart on idx 0 mid-frame: partial sums discarded, bin 0 kept.
    frame(0, 5, 16'sd100, 16'sd0);
    cyc(1'b1, 5'd0, 16'sd1, -16'sd1, 1'b0);
    n_vec++; if (seq_err !== 1'b1) begin n_err++; $display("FAIL restart_pulse: got %b expected 1", seq_err); end
    frame(1, 31, 16'sd1, -16'sd1);
    idle();
    n_vec++; if (freqs !== c_f8 || fft_done !== 1'b1) begin n_err++; $display("FAIL restart_freqs: freqs %h done %b expected %h done 1", freqs, fft_done, c_f8); end
    do_ack();
  endtask

  task automatic test_drop();
    frame(0, 31, 16'sd1, -16'sd1);
    idle();
    frame(0, 31, 16'sd3, 16'sd0);
    idle();
    n_vec++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL drop_cnt: got %0d expected 1", drop_cnt); end
    n_vec++; if (freqs !== c_f8) begin n_err++; $display("FAIL drop_held: got %h expected %h", freqs, c_f8); end
    n_vec++; if (fft_done !== 1'b1) begin n_err++; $display("FAIL drop_done: got %b expected 1", fft_done); end
    do_ack();
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL drop_ack: done got %b expected 0", fft_done); end
  endtask

  task automatic test_back_to_back();
    frame(0, 31, 16'sd1, -16'sd1);
    // Next frame's bin 0 arrives in the publish cycle of the first.
    cyc(1'b1, 5'd0, 16'sd3, 16'sd0, 1'b0);
    n_vec++; if (freqs !== c_f8 || fft_done !== 1'b1) begin n_err++; $display("FAIL b2b_first: freqs %h done %b expected %h done 1", freqs, fft_done, c_f8); end
    frame(1, 31, 16'sd3, 16'sd0);
    // Ack in the exact publish cycle of the second frame.
    do_ack();
    n_vec++; if (fft_done !== 1'b1) begin n_err++; $display("FAIL ackpub_done: got %b expected 1", fft_done); end
    n_vec++; if (freqs !== c_f12) begin n_err++; $display("FAIL ackpub_freqs: got %h expected %h", freqs, c_f12); end
    n_vec++; if (drop_cnt !== 8'd1) begin n_err++; $display("FAIL ackpub_drop: got %0d expected 1", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    frame(0, 17, 16'sd1, -16'sd1);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (freqs !== 256'd0) begin n_err++; $display("FAIL rst_freqs: got %h expected 0", freqs); end
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b expected 0", fft_done); end
    n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop: got %0d expected 0", drop_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    // Frame starting mid-way must be ignored.
    frame(5, 31, 16'sd1, -16'sd1);
    idle();
    idle();
    n_vec++; if (fft_done !== 1'b0) begin n_err++; $display("FAIL late_start_done: got %b expected 0", fft_done); end
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL late_start_err: got %b expected 0", seq_err); end
    frame(0, 31, 16'sd0, -16'sd5);
    idle();
    n_vec++; if (freqs !== c_f20 || fft_done !== 1'b1) begin n_err++; $display("FAIL post_rst_frame: freqs %h done %b expected %h done 1", freqs, fft_done, c_f20); end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    c_f8      = {8{32'd8}};
    c_f12     = {8{32'd12}};
    c_f20     = {8{32'd20}};
    c_fmax    = {32'h0001_0000, 224'd0};
    rst_n     = 1'b0;
    bin_valid = 1'b0;
    bin_idx   = 5'd0;
    bin_re    = 16'sd0;
    bin_im    = 16'sd0;
    ack       = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_unit_frame();
    test_max_bin();
    test_seq_err();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
